devolvedor_moedas: RTL and testbench

Change-return coin ejector for the vending machine. It is the transmit side of the 2-bit coin interface that the coin accumulator receives. On a start pulse it takes an amount in value units and breaks it greedily into coins of 5, 2 and 1. It then drives each coin onto the 2-bit coin bus as a timed pulse followed by an idle gap, and signals completion. It sits between the comparator's return-coins decision and the physical ejector, or the accumulator in loopback test.

---
 rtl/devolvedor_moedas.sv | 184 ++++++++++++++++++
 tb/tb_devolvedor_moedas.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/devolvedor_moedas.sv
`default_nettype none
// ============================================================================
// Module   : devolvedor_moedas
// Purpose  : Change-return coin ejector. On an accepted start it captures an
//            amount and breaks it greedily into coins of 5, 2 and 1 units.
//            Each coin is driven on the 2-bit coin bus for PULSO_CICLOS
//            cycles, followed by PAUSA_CICLOS idle cycles. A one-cycle
//            completion pulse ends the return.
// Ports    : clk         - system clock, rising edge
//            reset       - asynchronous active-high reset
//            iniciar     - start request, honoured only when idle
//            valor       - amount to return, captured on accepted start
//            moeda_out   - coin code: 00 none, 01 = 1, 10 = 2, 11 = 5
//            ocupado     - high while a return is in progress
//            fim         - one-cycle completion pulse
//            num_moedas  - coins emitted in the current or last return
// Revision : 1.0 - initial release
// ============================================================================
module devolvedor_moedas #(
  parameter int PULSO_CICLOS  = 4,
  parameter int PAUSA_CICLOS  = 2,
  parameter int LARGURA_VALOR = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     iniciar,
  input  logic [LARGURA_VALOR-1:0] valor,
  output logic [1:0]               moeda_out,
  output logic                     ocupado,
  output logic                     fim,
  output logic [3:0]               num_moedas
);

  // Counter holds at most max(P,Q)-1.
  localparam int CNT_MAX = (PULSO_CICLOS > PAUSA_CICLOS) ? PULSO_CICLOS : PAUSA_CICLOS;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  // Coin comparisons need at least 3 bits so that the value 5 is representable.
  localparam int EXT_W   = (LARGURA_VALOR > 3) ? LARGURA_VALOR : 3;

  localparam logic [CNT_W-1:0] c_pulso_carga = CNT_W'(PULSO_CICLOS - 1);
  localparam logic [CNT_W-1:0] c_pausa_carga = CNT_W'(PAUSA_CICLOS - 1);

  localparam logic [1:0] c_cod_nada = 2'b00;
  localparam logic [1:0] c_cod_um   = 2'b01;
  localparam logic [1:0] c_cod_dois = 2'b10;
  localparam logic [1:0] c_cod_cinco = 2'b11;

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    SELECIONA = 3'd1,
    PULSO     = 3'd2,
    PAUSA     = 3'd3,
    FIM       = 3'd4
  } estado_t;

  estado_t                  estado_q, estado_d;
  logic [LARGURA_VALOR-1:0] restante_q, restante_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [1:0]               moeda_q, moeda_d;
  logic                     ocupado_q, ocupado_d;
  logic                     fim_q, fim_d;
  logic [3:0]               num_q, num_d;

  // Greedy coin choice for the current remaining amount.
  logic [EXT_W-1:0]         w_rest_ext;
  logic [EXT_W-1:0]         w_valor_moeda;
  logic [1:0]               w_codigo;
  logic [LARGURA_VALOR-1:0] w_rest_sub;

  always_comb begin
    w_rest_ext = EXT_W'(restante_q);
    if (w_rest_ext >= EXT_W'(5)) begin
      w_codigo      = c_cod_cinco;
      w_valor_moeda = EXT_W'(5);
    end else if (w_rest_ext >= EXT_W'(2)) begin
      w_codigo      = c_cod_dois;
      w_valor_moeda = EXT_W'(2);
    end else begin
      w_codigo      = c_cod_um;
      w_valor_moeda = EXT_W'(1);
    end
    // Only used when restante is nonzero, so the chosen coin never exceeds it.
    w_rest_sub = LARGURA_VALOR'(w_rest_ext - w_valor_moeda);
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q   <= OCIOSO;
      restante_q <= '0;
      cnt_q      <= '0;
      moeda_q    <= c_cod_nada;
      ocupado_q  <= 1'b0;
      fim_q      <= 1'b0;
      num_q      <= 4'd0;
    end else begin
      estado_q   <= estado_d;
      restante_q <= restante_d;
      cnt_q      <= cnt_d;
      moeda_q    <= moeda_d;
      ocupado_q  <= ocupado_d;
      fim_q      <= fim_d;
      num_q      <= num_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    estado_d   = estado_q;
    restante_d = restante_q;
    cnt_d      = cnt_q;
    moeda_d    = moeda_q;
    ocupado_d  = ocupado_q;
    fim_d      = 1'b0;
    num_d      = num_q;

    case (estado_q)
      OCIOSO: begin
        moeda_d   = c_cod_nada;
        ocupado_d = 1'b0;
        if (iniciar) begin
          restante_d = valor;
          num_d      = 4'd0;
          ocupado_d  = 1'b1;
          estado_d   = SELECIONA;
        end
      end

      SELECIONA: begin
        if (restante_q == '0) begin
          moeda_d  = c_cod_nada;
          fim_d    = 1'b1;
          estado_d = FIM;
        end else begin
          moeda_d    = w_codigo;
          restante_d = w_rest_sub;
          num_d      = (num_q == 4'hF) ? num_q : num_q + 4'd1;
          cnt_d      = c_pulso_carga;
          estado_d   = PULSO;
        end
      end

      PULSO: begin
        // The SELECIONA edge provides the first of the P held cycles,
        // so the counter starts at P-1 and the coin drops when it hits 0.
        if (cnt_q == '0) begin
          moeda_d  = c_cod_nada;
          cnt_d    = c_pausa_carga;
          estado_d = PAUSA;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      PAUSA: begin
        moeda_d = c_cod_nada;
        if (cnt_q == '0) begin
          estado_d = SELECIONA;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      FIM: begin
        moeda_d   = c_cod_nada;
        ocupado_d = 1'b0;
        estado_d  = OCIOSO;
      end

      default: begin
        moeda_d   = c_cod_nada;
        ocupado_d = 1'b0;
        estado_d  = OCIOSO;
      end
    endcase
  end

  assign moeda_out  = moeda_q;
  assign ocupado    = ocupado_q;
  assign fim        = fim_q;
  assign num_moedas = num_q;

endmodule
`default_nettype wire

// File: tb/tb_devolvedor_moedas.sv
`default_nettype none
// ============================================================================
// Module   : tb_devolvedor_moedas
// Purpose  : Directed self-checking bench for devolvedor_moedas with
//            PULSO_CICLOS = 4 and PAUSA_CICLOS = 2 (coin period 7 cycles).
// Revision : 1.0 - initial release
// ============================================================================
module tb_devolvedor_moedas;

  logic       clk;
  logic       reset;
  logic       iniciar;
  logic [3:0] valor;
  logic [1:0] moeda_out;
  logic       ocupado;
  logic       fim;
  logic [3:0] num_moedas;

  int total = 0;
  int bad   = 0;

  // Per-cycle samples taken on the falling edge; index k is after edge E0+k.
  logic [1:0] tr_m [0:63];
  logic       tr_f [0:63];
  logic       tr_o [0:63];

  devolvedor_moedas #(
    .PULSO_CICLOS (4),
    .PAUSA_CICLOS (2),
    .LARGURA_VALOR(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .iniciar   (iniciar),
    .valor     (valor),
    .moeda_out (moeda_out),
    .ocupado   (ocupado),
    .fim       (fim),
    .num_moedas(num_moedas)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at sample point s0 (after E0).
  task automatic start(input logic [3:0] v);
    iniciar = 1'b1;
    valor   = v;
    @(negedge clk);
    iniciar = 1'b0;
    valor   = 4'd9;  // later changes must have no effect
  endtask

  task automatic capture(input int n, input int inj_at, input logic [3:0] inj_val);
    for (int i = 0; i < n; i++) begin
      tr_m[i] = moeda_out;
      tr_f[i] = fim;
      tr_o[i] = ocupado;
      if (i == inj_at) begin
        iniciar = 1'b1;
        valor   = inj_val;
      end else begin
        iniciar = 1'b0;
      end
      @(negedge clk);
    end
    iniciar = 1'b0;
  endtask

  function automatic int coin_val(input logic [1:0] c);
    case (c)
      2'b11:   return 5;
      2'b10:   return 2;
      2'b01:   return 1;
      default: return 0;
    endcase
  endfunction

  // Loopback accumulator: adds a coin's value on each 00 -> nonzero step.
  function automatic int soma(input int n);
    int s = 0;
    for (int i = 1; i < n; i++)
      if (tr_m[i] != 2'b00 && tr_m[i-1] == 2'b00) s += coin_val(tr_m[i]);
    return s;
  endfunction

  function automatic int ciclos_ativos(input int n);
    int c = 0;
    for (int i = 0; i < n; i++)
      if (tr_m[i] != 2'b00) c++;
    return c;
  endfunction

  function automatic int pulsos_fim(input int n);
    int c = 0;
    for (int i = 0; i < n; i++)
      if (tr_f[i]) c++;
    return c;
  endfunction

  initial begin
    reset   = 1'b1;
    iniciar = 1'b0;
    valor   = 4'd0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_moeda",   32'(moeda_out),  32'd0);
    check("rst_ocupado", 32'(ocupado),    32'd0);
    check("rst_fim",     32'(fim),        32'd0);
    check("rst_num",     32'(num_moedas), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_ocupado", 32'(ocupado), 32'd0);

    // valor = 8 -> 5, 2, 1
    start(4'd8);
    capture(26, -1, 4'd0);
    check("v8_ocup_s0",  32'(tr_o[0]),  32'd1);
    check("v8_m_s0",     32'(tr_m[0]),  32'd0);
    check("v8_m_s1",     32'(tr_m[1]),  32'd3);
    check("v8_m_s4",     32'(tr_m[4]),  32'd3);
    check("v8_m_s5",     32'(tr_m[5]),  32'd0);
    check("v8_m_s7",     32'(tr_m[7]),  32'd0);
    check("v8_m_s8",     32'(tr_m[8]),  32'd2);
    check("v8_m_s11",    32'(tr_m[11]), 32'd2);
    check("v8_m_s12",    32'(tr_m[12]), 32'd0);
    check("v8_m_s15",    32'(tr_m[15]), 32'd1);
    check("v8_m_s18",    32'(tr_m[18]), 32'd1);
    check("v8_m_s19",    32'(tr_m[19]), 32'd0);
    check("v8_fim_s21",  32'(tr_f[21]), 32'd0);
    check("v8_fim_s22",  32'(tr_f[22]), 32'd1);
    check("v8_fim_s23",  32'(tr_f[23]), 32'd0);
    check("v8_ocup_s22", 32'(tr_o[22]), 32'd1);
    check("v8_ocup_s23", 32'(tr_o[23]), 32'd0);
    check("v8_active",   32'(ciclos_ativos(26)), 32'd12);
    check("v8_sum",      32'(soma(26)), 32'd8);
    check("v8_num",      32'(num_moedas), 32'd3);

    // valor = 0 -> no coin, fim after E1
    start(4'd0);
    capture(5, -1, 4'd0);
    check("v0_num_s0",  32'(num_moedas), 32'd0);
    check("v0_ocup_s0", 32'(tr_o[0]), 32'd1);
    check("v0_fim_s0",  32'(tr_f[0]), 32'd0);
    check("v0_fim_s1",  32'(tr_f[1]), 32'd1);
    check("v0_fim_s2",  32'(tr_f[2]), 32'd0);
    check("v0_ocup_s2", 32'(tr_o[2]), 32'd0);
    check("v0_active",  32'(ciclos_ativos(5)), 32'd0);

    // valor = 15 -> 5, 5, 5; loopback sum 15
    start(4'd15);
    capture(25, -1, 4'd0);
    check("v15_m_s1",  32'(tr_m[1]),  32'd3);
    check("v15_m_s8",  32'(tr_m[8]),  32'd3);
    check("v15_m_s15", 32'(tr_m[15]), 32'd3);
    check("v15_fim",   32'(tr_f[22]), 32'd1);
    check("v15_nfim",  32'(pulsos_fim(25)), 32'd1);
    check("v15_sum",   32'(soma(25)), 32'd15);
    check("v15_num",   32'(num_moedas), 32'd3);

    // valor = 7 with iniciar/valor=3 re-pulsed during PULSO -> 5, 2 only
    start(4'd7);
    capture(18, 2, 4'd3);
    check("v7_m_s1",  32'(tr_m[1]),  32'd3);
    check("v7_m_s8",  32'(tr_m[8]),  32'd2);
    check("v7_m_s15", 32'(tr_m[15]), 32'd0);
    check("v7_fim",   32'(tr_f[15]), 32'd1);
    check("v7_sum",   32'(soma(18)), 32'd7);
    check("v7_num",   32'(num_moedas), 32'd2);

    // Next start after fim is accepted: valor = 3 -> 2, 1
    start(4'd3);
    capture(18, -1, 4'd0);
    check("v3_ocup_s0", 32'(tr_o[0]), 32'd1);
    check("v3_m_s1",    32'(tr_m[1]), 32'd2);
    check("v3_m_s8",    32'(tr_m[8]), 32'd1);
    check("v3_fim",     32'(tr_f[15]), 32'd1);
    check("v3_num",     32'(num_moedas), 32'd2);

    // Reset mid-PULSO of the second coin of valor = 7
    start(4'd7);
    capture(10, -1, 4'd0);
    check("rs_m_s9", 32'(tr_m[9]), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    check("rs_async_moeda",   32'(moeda_out), 32'd0);
    check("rs_async_ocupado", 32'(ocupado),   32'd0);
    capture(3, -1, 4'd0);
    check("rs_nofim", 32'(pulsos_fim(3)), 32'd0);
    reset = 1'b0;
    capture(3, -1, 4'd0);
    check("rs_after_nofim", 32'(pulsos_fim(3)), 32'd0);
    check("rs_after_idle",  32'(ciclos_ativos(3)), 32'd0);

    // After release, valor = 1 -> single 01 coin
    start(4'd1);
    capture(12, -1, 4'd0);
    check("v1_m_s1",  32'(tr_m[1]), 32'd1);
    check("v1_m_s5",  32'(tr_m[5]), 32'd0);
    check("v1_fim",   32'(tr_f[8]), 32'd1);
    check("v1_sum",   32'(soma(12)), 32'd1);
    check("v1_num",   32'(num_moedas), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
